// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (receiver FSM states,
//               mid-bit sample offsets, parity modes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_t;

    localparam int OS_DEFAULT = 16;

    // Offsets of the three vote samples relative to OVERSAMPLE/2
    localparam int MID_LO = -1;
    localparam int MID    = 0;
    localparam int MID_HI = 1;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for rx plus the mid-bit sample register
//               feeding a 3-way majority vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    input  logic i_sample,
    output logic o_rxs,
    output logic o_vote
);

    logic [1:0] r_sync;
    logic [1:0] r_samp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
            r_samp <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            if (i_sample) begin
                r_samp <= {r_samp[0], r_sync[1]};
            end
        end
    end

    assign o_rxs = r_sync[1];

    // The third sample is the live synchronised value at the decision tick
    assign o_vote = (r_samp[1] & r_samp[0]) |
                    (r_samp[1] & o_rxs)     |
                    (r_samp[0] & o_rxs);

endmodule

`default_nettype wire

// File: rtl/uart_rx_os.sv
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampled UART receiver with majority vote, valid/ready
//               output register, frame/parity/overrun/break reporting.
//               Define UART_RX_PARITY_EN to add a parity bit to the frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OS_DEFAULT,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 stop_error,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int c_SC_W = $clog2(OVERSAMPLE);
    localparam int c_BC_W = $clog2(DATA_BITS);
    localparam logic [c_SC_W-1:0] c_MID_LO  = c_SC_W'(OVERSAMPLE / 2 + MID_LO);
    localparam logic [c_SC_W-1:0] c_MID     = c_SC_W'(OVERSAMPLE / 2 + MID);
    localparam logic [c_SC_W-1:0] c_MID_HI  = c_SC_W'(OVERSAMPLE / 2 + MID_HI);
    localparam logic [c_SC_W-1:0] c_LAST_SC = c_SC_W'(OVERSAMPLE - 1);
    localparam logic [c_BC_W-1:0] c_LAST_BIT = c_BC_W'(DATA_BITS - 1);

    rx_state_t              r_state;
    rx_state_t              w_next;
    logic [c_SC_W-1:0]      r_sc;
    logic [c_BC_W-1:0]      r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_serr;
    logic                   r_overrun;
    logic                   r_brk;

    logic w_rxs;
    logic w_vote;
    logic w_sample;
    logic w_mid;
    logic w_end;
    logic w_is_break;
    logic w_perr;
    logic w_shift_en;
    logic w_done;
    logic w_brk;
    logic w_load;
    logic w_drop;
    logic w_accept;

    assign w_sample = tick && ((r_sc == c_MID_LO) || (r_sc == c_MID));
    assign w_mid    = tick && (r_sc == c_MID_HI);
    assign w_end    = tick && (r_sc == c_LAST_SC);

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_rx     (rx),
        .i_sample (w_sample),
        .o_rxs    (w_rxs),
        .o_vote   (w_vote)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic w_par_en;

    assign w_par_en   = (r_state == ST_PARITY) && w_mid;
    assign w_is_break = !w_vote && (r_shift == '0) && !r_par;
    assign w_perr     = ((^r_shift) ^ r_par) != (PARITY_ODD == PAR_ODD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_par_en) begin
            r_par <= w_vote;
        end
    end
`else
    assign w_is_break = !w_vote && (r_shift == '0);
    assign w_perr     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (tick && !w_rxs) w_next = ST_START;
            end
            ST_START: begin
                if (w_mid && w_vote) w_next = ST_IDLE;
                else if (w_end)      w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_end && (r_bit == c_LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_end) w_next = ST_STOP;
            end
`endif
            // Stop resolves at the decision point so a following start edge is not missed
            ST_STOP: begin
                if (w_mid) w_next = w_is_break ? ST_BRK_WAIT : ST_IDLE;
            end
            ST_BRK_WAIT: begin
                if (tick && w_rxs) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift_en = (r_state == ST_DATA) && w_mid;
        w_done     = (r_state == ST_STOP) && w_mid && !w_is_break;
        w_brk      = (r_state == ST_STOP) && w_mid && w_is_break;
        w_accept   = r_valid && rx_ready;
        w_load     = w_done && (!r_valid || rx_ready);
        w_drop     = w_done && r_valid && !rx_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sc    <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state != w_next) begin
                r_sc <= '0;
            end else if (tick && (r_state != ST_IDLE) && (r_state != ST_BRK_WAIT)) begin
                r_sc <= (r_sc == c_LAST_SC) ? '0 : r_sc + 1'b1;
            end

            if (r_state != ST_DATA) begin
                r_bit <= '0;
            end else if (w_end) begin
                r_bit <= r_bit + 1'b1;
            end

            if (w_shift_en) begin
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_serr    <= 1'b0;
            r_overrun <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            r_brk     <= w_brk;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_perr  <= w_perr;
                r_serr  <= !w_vote;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign parity_error = r_perr;
    assign stop_error   = r_serr;
    assign overrun      = r_overrun;
    assign break_det    = r_brk;

endmodule

`default_nettype wire
